// File: rtl/jump_lut.sv
// jump_lut: key-indexed jump-target table with single-cycle lookups and a
// background clear sweep.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   rd_req     lookup request, accepted when rd_ready=1
//   rd_key     lookup key
//   rd_ready   high in IDLE, low while sweeping
//   rd_valid   one-cycle pulse; rd_addr/rd_hit valid (both hold otherwise)
//   rd_addr    stored target address (0 on miss)
//   rd_hit     entry was programmed
//   wr_en      program entry wr_key with wr_data (IDLE only)
//   wr_key     entry to program
//   wr_data    target address to store
//   clr_start  start a full-table clear sweep (IDLE only)
//   busy       clear sweep in progress
//
// Build option: define JUMP_LUT_BYPASS_EN to forward a same-cycle,
// same-key write to the lookup result; otherwise the lookup sees the old
// entry contents.
module jump_lut #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned KEY_W  = 5,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [KEY_W-1:0]  rd_key,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              clr_start,
  output logic              busy
);

  localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q;
  logic [KEY_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   data_q [DEPTH];
  logic                valid_q [DEPTH];
  logic                rd_valid_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_hit_q;

  logic                rd_accept;
  logic                rd_in_range;
  logic                wr_ok;
  logic [ADDR_W-1:0]   lkp_addr;
  logic                lkp_hit;

  // Handshake and write qualification; everything is ignored while sweeping.
  assign rd_accept   = rd_req && (state_q == IDLE);
  assign rd_in_range = 32'(rd_key) < DEPTH;
  assign wr_ok       = wr_en && (state_q == IDLE) && (32'(wr_key) < DEPTH);

  // Lookup result as seen at the accepting edge (pre-write unless bypassed).
  always_comb begin
    lkp_addr = '0;
    lkp_hit  = 1'b0;
    if (rd_in_range && valid_q[rd_key]) begin
      lkp_addr = data_q[rd_key];
      lkp_hit  = 1'b1;
    end
`ifdef JUMP_LUT_BYPASS_EN
    if (wr_ok && (wr_key == rd_key)) begin
      lkp_addr = wr_data;
      lkp_hit  = 1'b1;
    end
`endif
  end

  // State machine, table storage and registered lookup response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_hit_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_addr_q <= lkp_addr;
        rd_hit_q  <= lkp_hit;
      end

      case (state_q)
        IDLE: begin
          // A write alongside clr_start still lands; the sweep starts next cycle.
          if (wr_ok) begin
            data_q[wr_key]  <= wr_data;
            valid_q[wr_key] <= 1'b1;
          end
          if (clr_start) begin
            state_q <= CLEAR;
            idx_q   <= '0;
          end
        end
        CLEAR: begin
          data_q[idx_q]  <= '0;
          valid_q[idx_q] <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + KEY_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rd_ready = (state_q == IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_hit   = rd_hit_q;

endmodule

// File: tb/tb_jump_lut.sv
// tb_jump_lut: scoreboard bench for jump_lut (DEPTH=32, KEY_W=5, ADDR_W=8).
module tb_jump_lut;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_req;
  logic [4:0] rd_key;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic       rd_hit;
  logic       wr_en;
  logic [4:0] wr_key;
  logic [7:0] wr_data;
  logic       clr_start;
  logic       busy;

  typedef struct {
    logic [7:0] addr;
    logic       hit;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] m_data [32];
  logic       m_valid [32];
  int         vectors = 0;
  int         miscompares = 0;

  jump_lut #(.DEPTH(32), .KEY_W(5), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_key    (rd_key),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .wr_en     (wr_en),
    .wr_key    (wr_key),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rd_valid: got addr=%0d hit=%0b, required no pulse", rd_addr, rd_hit);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rd_addr !== e.addr || rd_hit !== e.hit) begin
          miscompares++;
          $display("FAIL lookup: got addr=%0d hit=%0b, required addr=%0d hit=%0b",
                   rd_addr, rd_hit, e.addr, e.hit);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_data[i]  = 8'd0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic write_entry(input int k, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_key  = 5'(k);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    m_data[k]  = d;
    m_valid[k] = 1'b1;
  endtask

  task automatic lookup(input int k);
    exp_t e;
    rd_req = 1'b1;
    rd_key = 5'(k);
    e.addr = m_valid[k] ? m_data[k] : 8'd0;
    e.hit  = m_valid[k];
    sb_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  // Bounded wait for all pending lookups to come back.
  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: %0d lookups outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0 || rd_addr !== 8'd0 || rd_hit !== 1'b0 || busy !== 1'b0 || rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b addr=%0d hit=%0b busy=%0b ready=%0b, required 0 0 0 0 1",
               rd_valid, rd_addr, rd_hit, busy, rd_ready);
    end
    @(posedge clk);
    #1;
    // Lookup presented together with reset must never respond.
    rd_req = 1'b1;
    rd_key = 5'd4;
    reset  = 1'b1;
    tick();
    rd_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_inflight: got rd_valid=%0b, required 0", rd_valid);
    end
    @(posedge clk);
    #1;
    lookup(4);
    drain("reset_lookup");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    write_entry(6, 8'd91);
    lookup(6);
    @(negedge clk);  // response pulse
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0 || rd_addr !== 8'd91 || rd_hit !== 1'b1) begin
      miscompares++;
      $display("FAIL hold: got valid=%0b addr=%0d hit=%0b, required 0 91 1", rd_valid, rd_addr, rd_hit);
    end
    @(posedge clk);
    #1;
    rd_req = 1'b1;
    rd_key = 5'd6;
    e.addr = 8'd91; e.hit = 1'b1;
    sb_q.push_back(e);
    tick();
    rd_key = 5'd7;
    e.addr = 8'd0; e.hit = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pulse1: got rd_valid=%0b, required 1", rd_valid);
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pulse2: got rd_valid=%0b, required 1", rd_valid);
    end
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got rd_valid=%0b, required 0", rd_valid);
    end
    @(posedge clk);
    #1;
    drain("b2b");
  endtask

  task automatic test_same_cycle();
    exp_t e;
    write_entry(9, 8'd142);
    wr_en   = 1'b1;
    wr_key  = 5'd9;
    wr_data = 8'd200;
    rd_req  = 1'b1;
    rd_key  = 5'd9;
`ifdef JUMP_LUT_BYPASS_EN
    e.addr = 8'd200;
`else
    e.addr = 8'd142;
`endif
    e.hit = 1'b1;
    sb_q.push_back(e);
    tick();
    wr_en  = 1'b0;
    rd_req = 1'b0;
    m_data[9]  = 8'd200;
    m_valid[9] = 1'b1;
    lookup(9);
    drain("same_cycle");
  endtask

  task automatic test_clear();
    exp_t e;
    int   cnt;
    for (int k = 0; k < 32; k++) write_entry(k, 8'(k * 7 + 3));
    // Lookup and write in the clr_start cycle both complete normally.
    rd_req    = 1'b1;
    rd_key    = 5'd3;
    e.addr    = m_data[3];
    e.hit     = 1'b1;
    sb_q.push_back(e);
    clr_start = 1'b1;
    wr_en     = 1'b1;
    wr_key    = 5'd5;
    wr_data   = 8'd77;
    tick();
    rd_req    = 1'b0;
    clr_start = 1'b0;
    wr_en     = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      vectors++;
      if (rd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_ready: cycle %0d got rd_ready=%0b, required 0", cnt, rd_ready);
      end
      if (cnt == 5) begin
        wr_en = 1'b1; wr_key = 5'd20; wr_data = 8'd99;
        rd_req = 1'b1; rd_key = 5'd20;
        clr_start = 1'b1;
      end
      if (cnt == 6) begin
        wr_en = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
      end
    end
    wr_en = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
    vectors++;
    if (cnt != 32) begin
      miscompares++;
      $display("FAIL sweep_length: got %0d busy cycles, required 32", cnt);
    end
    vectors++;
    if (rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_done_ready: got rd_ready=%0b, required 1", rd_ready);
    end
    model_clear();
    @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) lookup(k);
    drain("after_clear");
  endtask

  task automatic test_reset_mid_clear();
    for (int k = 0; k < 32; k++) write_entry(k, 8'(255 - k));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rd_ready !== 1'b1 || rd_valid !== 1'b0 || rd_addr !== 8'd0 || rd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%0b ready=%0b valid=%0b addr=%0d hit=%0b, required 0 1 0 0 0",
               busy, rd_ready, rd_valid, rd_addr, rd_hit);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) lookup(k);
    drain("after_abort");
    write_entry(17, 8'd254);
    lookup(17);
    drain("after_abort_write");
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_key = '0;
    wr_en = 1'b0; wr_key = '0; wr_data = '0; clr_start = 1'b0;
    model_clear();
    test_reset();
    test_back_to_back();
    test_same_cycle();
    test_clear();
    test_reset_mid_clear();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
